fpu_writeback: RTL
==================

// Module: fpu_writeback
// PURPOSE
//  Write-side front end of the FP register file. Merges results from the FPU datapath and the FP load
//  unit onto the single register-file write port (wen/rdaddr/wdata), arbitrating round-robin.
//  Keeps a per-register busy scoreboard: set at FP instruction issue, cleared at writeback.
//  Supplies the decode stage with a RAW-hazard flag for rs1/rs2/rs3.
// PARAMETERS
//  XLEN   32  data width of results and register-file write data
//  NREG   32  number of FP registers; AW = $clog2(NREG) = 5
// PORTS
//  clock       in   1     rising-edge clock
//  rstn        in   1     asynchronous active-low reset
//  issue_valid in   1     decode issues an FP-writing instruction
//  issue_rd    in   AW    its destination register
//  issue_ready out  1     issue accepted this cycle (scoreboard free for issue_rd)
//  fpu_valid   in   1     FPU result valid
//  fpu_rd      in   AW    FPU result destination
//  fpu_data    in   XLEN  FPU result
//  fpu_ready   out  1     FPU result accepted this cycle
//  ld_valid    in   1     load result valid
//  ld_rd       in   AW    load destination
//  ld_data     in   XLEN  load data
//  ld_ready    out  1     load result accepted this cycle
//  rs1_addr/rs2_addr/rs3_addr  in  AW  decode source registers
//  rs1_use/rs2_use/rs3_use     in  1   source actually read
//  hazard      out  1     any used source is busy
//  rf_wen      out  1     register-file write enable (registered)
//  rf_waddr    out  AW    register-file write address (registered)
//  rf_wdata    out  XLEN  register-file write data (registered)
//  busy        out  NREG  scoreboard vector (registered)
// BEHAVIOUR
//  - Reset (async, rstn low): rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, rr pointer=FPU-first.
//    In-flight results are dropped; reset mid-transfer leaves no partial write.
//  - Handshake: transfer when valid&ready at a rising edge. ready is combinational from valid and
//    the arbiter grant; ready never depends on its own source's data. Producers hold valid/rd/data
//    stable until accepted.
//  - Arbitration: one grant per cycle. Only one valid -> it is granted. Both valid -> grant the
//    source not granted in the most recent granted cycle; pointer updates only on a grant.
//  - Latency: result accepted at edge N -> rf_wen=1 with its rd/data during cycle N+1, for exactly
//    one cycle. Back-to-back grants give back-to-back writes. No grant -> rf_wen=0, waddr/wdata hold.
//  - Scoreboard: busy[r] set at the edge where issue_valid&issue_ready with issue_rd=r; cleared at the
//    edge after the write commits (edge where rf_wen=1 and rf_waddr=r).
//    issue_ready = !busy[issue_rd] | (rf_wen & rf_waddr==issue_rd). On a same-edge clear and set of
//    one register, set wins (busy stays 1).
//  - hazard = (rs1_use&busy[rs1_addr]) | (rs2_use&busy[rs2_addr]) | (rs3_use&busy[rs3_addr]);
//    purely combinational, no bypass from rf_wen (register file is read next cycle).
//  - Writeback to a register that is not busy is legal (written, busy unchanged); verification flags
//    it as a protocol warning only. Register 0 is an ordinary FP register, not hardwired.
//  - Address width: rd/rs are AW bits; no out-of-range values exist when NREG is a power of two.
// STRUCTURE
//  - Package fpu_wb_pkg: XLEN/NREG/AW constants, typedef fp_reg_t (AW bits), typedef wb_src_e {SRC_FPU, SRC_LD}.
//  - Sub-module fpu_wb_rr_arb: 2-requester round-robin arbiter (req[1:0], grant[1:0], pointer flop).
//  - Top: arbiter, output register stage, scoreboard register vector with set/clear logic,
//    hazard compare.
// TESTING
//  1 Reset: hold rstn low mid-stream with fpu_valid=1 -> rf_wen=0, busy=0; first write after release.
//  2 Single FPU result rd=5, data=0x3F800000 at edge N -> rf_wen=1, waddr=5, wdata=0x3F800000 in N+1
//    only.
//  3 fpu_valid & ld_valid held for 4 cycles (rd=1 and rd=2) -> grants FPU,LD,FPU,LD; writes to 1,2,1,2
//    back to back.
//  4 Issue rd=7 -> busy[7]=1; rs2_addr=7, rs2_use=1 -> hazard=1; ld write rd=7 -> busy[7]=0 the edge
//    after rf_wen; then hazard=0.
//  5 busy[3]=1, rf_wen to rd=3 coincides with issue rd=3 -> issue_ready=1, busy[3] remains 1.
//  6 busy[9]=1, issue rd=9 without writeback -> issue_ready=0 until rd=9 write commits.

Source files
------------

// File: rtl/fpu_wb_pkg.sv
// rtl/fpu_wb_pkg.sv - shared constants and types for the FP register-file writeback front end
package fpu_wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0] fp_reg_t;

  typedef enum logic {
    SRC_FPU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/fpu_wb_rr_arb.sv
// rtl/fpu_wb_rr_arb.sv - two-requester round-robin arbiter; bit 0 is the FPU, bit 1 the load unit
module fpu_wb_rr_arb
  import fpu_wb_pkg::*;
(
  input  logic       clock,
  input  logic       rstn,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  wb_src_e prio_q;
  wb_src_e prio_d;

  // prio_q names the source that wins when both request
  always_comb begin
    grant_o = 2'b00;
    if (req_i[0] && (!req_i[1] || prio_q == SRC_FPU)) begin
      grant_o[0] = 1'b1;
    end else if (req_i[1]) begin
      grant_o[1] = 1'b1;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (grant_o[0]) begin
      prio_d = SRC_LD;
    end else if (grant_o[1]) begin
      prio_d = SRC_FPU;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      prio_q <= SRC_FPU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/fpu_writeback.sv
// rtl/fpu_writeback.sv - merges FPU and load results onto the FP register-file write port
// and keeps the per-register busy scoreboard used for RAW hazard detection at decode.
module fpu_writeback
  import fpu_wb_pkg::*;
(
  input  logic            clock,
  input  logic            rstn,
  input  logic            issue_valid,
  input  fp_reg_t         issue_rd,
  output logic            issue_ready,
  input  logic            fpu_valid,
  input  fp_reg_t         fpu_rd,
  input  logic [XLEN-1:0] fpu_data,
  output logic            fpu_ready,
  input  logic            ld_valid,
  input  fp_reg_t         ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  fp_reg_t         rs1_addr,
  input  fp_reg_t         rs2_addr,
  input  fp_reg_t         rs3_addr,
  input  logic            rs1_use,
  input  logic            rs2_use,
  input  logic            rs3_use,
  output logic            hazard,
  output logic            rf_wen,
  output fp_reg_t         rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy
);

  logic [1:0]      grant;
  wb_src_e         sel;
  logic            rf_wen_q,   rf_wen_d;
  fp_reg_t         rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q,     busy_d;
  logic [NREG-1:0] set_vec,    clr_vec;

  fpu_wb_rr_arb u_arb (
    .clock   (clock),
    .rstn    (rstn),
    .req_i   ({ld_valid, fpu_valid}),
    .grant_o (grant)
  );

  assign fpu_ready = grant[0];
  assign ld_ready  = grant[1];
  assign sel       = grant[1] ? SRC_LD : SRC_FPU;

  // Address and data hold their last value when nothing is granted
  always_comb begin
    rf_wen_d   = |grant;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (|grant) begin
      rf_waddr_d = (sel == SRC_LD) ? ld_rd   : fpu_rd;
      rf_wdata_d = (sel == SRC_LD) ? ld_data : fpu_data;
    end
  end

  // A committing write frees its register this edge, so a re-issue may proceed at once
  assign issue_ready = !busy_q[issue_rd] || (rf_wen_q && rf_waddr_q == issue_rd);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_ready) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (rf_wen_q) begin
      clr_vec[rf_waddr_q] = 1'b1;
    end
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  // No bypass from the write port: the register file is read a cycle later
  assign hazard = (rs1_use && busy_q[rs1_addr]) ||
                  (rs2_use && busy_q[rs2_addr]) ||
                  (rs3_use && busy_q[rs3_addr]);

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule
